// File: rtl/eth_rmii_tx_if.sv
// Upstream byte handshake plus RMII transmit pins for eth_rmii_tx.
// master = frame source / line monitor side, slave = the transmitter.
interface eth_rmii_tx_if;
  logic       txpacket;
  logic [7:0] txdata;
  logic       txadvance;
  logic       txbusy;
  logic       rmii_txen;
  logic [1:0] rmii_txd;

  modport master (
    output txpacket, txdata,
    input  txadvance, txbusy, rmii_txen, rmii_txd
  );

  modport slave (
    input  txpacket, txdata,
    output txadvance, txbusy, rmii_txen, rmii_txd
  );
endinterface

// File: rtl/eth_rmii_tx.sv
// RMII Ethernet transmitter: preamble/SFD, byte-fed data, optional pad to 60 bytes,
// CRC-32 FCS and inter-packet gap, one dibit per 50 MHz clock.
module eth_rmii_tx #(
  parameter int unsigned PAD        = 1,
  parameter int unsigned IPG_CYCLES = 48
) (
  input logic         clk,
  input logic         reset,
  eth_rmii_tx_if.slave bus
);

  localparam int unsigned CntW = (IPG_CYCLES > 32) ? $clog2(IPG_CYCLES) : 5;

  typedef enum logic [2:0] {StIdle, StPreamble, StData, StPad, StFcs, StIpg} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [5:0]      byte_q, byte_d;
  logic [31:0]     crc_q, crc_d;
  logic [7:0]      shift_q, shift_d;
  logic            txen_q, txen_d;
  logic [1:0]      txd_q, txd_d;
  logic            busy_q, busy_d;
  logic            adv, end_byte, load;
  logic [7:0]      load_byte;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CntW'(1);
    byte_d    = byte_q;
    crc_d     = crc_q;
    shift_d   = shift_q;
    txen_d    = txen_q;
    txd_d     = txd_q;
    adv       = 1'b0;
    end_byte  = 1'b0;
    load      = 1'b0;
    load_byte = 8'h00;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (bus.txpacket) begin
          state_d = StPreamble;
          txen_d  = 1'b1;
          txd_d   = 2'b01;
          crc_d   = '1;
          byte_d  = '0;
          shift_d = '0;
        end
      end
      StPreamble: begin
        txd_d    = (cnt_q == CntW'(30)) ? 2'b11 : 2'b01;
        end_byte = (cnt_q == CntW'(31));
      end
      StData, StPad: begin
        txd_d    = shift_q[1:0];
        shift_d  = shift_q >> 2;
        end_byte = (cnt_q == CntW'(3));
      end
      StFcs: begin
        // crc_q already holds the complemented CRC and is shifted out in place.
        txd_d = crc_q[1:0];
        crc_d = crc_q >> 2;
        if (cnt_q == CntW'(15)) begin
          state_d = StIpg;
          txen_d  = 1'b0;
          txd_d   = 2'b00;
          cnt_d   = '0;
          crc_d   = '1;
        end
      end
      StIpg: begin
        // The single IDLE cycle completes the gap, so the line is quiet IPG_CYCLES clocks.
        if (cnt_q == CntW'(IPG_CYCLES - 2)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (end_byte) begin
      cnt_d = '0;
      if (state_q != StPad && bus.txpacket) begin
        adv       = 1'b1;
        state_d   = StData;
        load      = 1'b1;
        load_byte = bus.txdata;
      end else if (PAD != 0 && byte_q < 6'd60) begin
        state_d = StPad;
        load    = 1'b1;
      end else begin
        state_d = StFcs;
        txd_d   = ~crc_q[1:0];
        crc_d   = (~crc_q) >> 2;
      end
    end

    if (load) begin
      txd_d   = load_byte[1:0];
      shift_d = {2'b00, load_byte[7:2]};
      crc_d   = crc_byte(crc_q, load_byte);
      byte_d  = (byte_q < 6'd60) ? byte_q + 6'd1 : byte_q;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      byte_q  <= '0;
      crc_q   <= '1;
      shift_q <= '0;
      txen_q  <= 1'b0;
      txd_q   <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      crc_q   <= crc_d;
      shift_q <= shift_d;
      txen_q  <= txen_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.txadvance = adv & ~reset;
  assign bus.txbusy    = busy_q;
  assign bus.rmii_txen = txen_q;
  assign bus.rmii_txd  = txd_q;

endmodule

// File: tb/tb_eth_rmii_tx.sv
// Bench for eth_rmii_tx: PAD=0 and PAD=1 instances driven by a byte source and checked
// against a frame-level model (preamble, data, pad, bit-serial CRC-32, dibit order).
module tb_eth_rmii_tx;
  typedef logic [7:0] bytes_t[$];

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #10 clk = ~clk;

  eth_rmii_tx_if bus0();
  eth_rmii_tx_if bus1();

  eth_rmii_tx #(.PAD(0), .IPG_CYCLES(48)) dut_p0 (.clk(clk), .reset(reset), .bus(bus0));
  eth_rmii_tx #(.PAD(1), .IPG_CYCLES(48)) dut_p1 (.clk(clk), .reset(reset), .bus(bus1));

  logic       tp[2];
  logic [7:0] td[2];
  logic       adv_w[2], busy_w[2], en_w[2];
  logic [1:0] txd_w[2];

  assign bus0.txpacket = tp[0];
  assign bus0.txdata   = td[0];
  assign bus1.txpacket = tp[1];
  assign bus1.txdata   = td[1];
  assign adv_w[0]  = bus0.txadvance;
  assign adv_w[1]  = bus1.txadvance;
  assign busy_w[0] = bus0.txbusy;
  assign busy_w[1] = bus1.txbusy;
  assign en_w[0]   = bus0.rmii_txen;
  assign en_w[1]   = bus1.rmii_txen;
  assign txd_w[0]  = bus0.rmii_txd;
  assign txd_w[1]  = bus1.rmii_txd;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Line monitor, sampled on the falling edge.
  logic [1:0] cap0[$], cap1[$], exp_q[$];
  int adv_cnt[2], rises[2], txd_bad[2], lo_run[2], busy_lo[2], last_gap[2], last_bgap[2];
  logic prev_en[2];

  task automatic clear_mon();
    cap0.delete();
    cap1.delete();
    for (int i = 0; i < 2; i++) begin
      adv_cnt[i] = 0; rises[i] = 0; txd_bad[i] = 0; lo_run[i] = 0;
      busy_lo[i] = 0; last_gap[i] = 0; last_bgap[i] = 0; prev_en[i] = 1'b0;
    end
  endtask

  initial begin
    clear_mon();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (adv_w[i]) adv_cnt[i]++;
        if (en_w[i]) begin
          if (!prev_en[i]) begin
            rises[i]++;
            last_gap[i]  = lo_run[i];
            last_bgap[i] = busy_lo[i];
          end
          if (i == 0) cap0.push_back(txd_w[i]);
          else        cap1.push_back(txd_w[i]);
          lo_run[i]  = 0;
          busy_lo[i] = 0;
        end else begin
          lo_run[i]++;
          if (!busy_w[i]) busy_lo[i]++;
          if (txd_w[i] != 2'b00) txd_bad[i]++;
        end
        prev_en[i] = en_w[i];
      end
    end
  end

  // Reference frame: preamble+SFD, data, zero pad, complemented reflected CRC, LSB dibit first.
  task automatic push_byte(input logic [7:0] v);
    for (int d = 0; d < 4; d++) exp_q.push_back(v[2*d +: 2]);
  endtask

  task automatic build_expected(input bytes_t data, input bit pad);
    bytes_t fr;
    logic [31:0] crc;
    logic fb;
    fr = data;
    if (pad) while (fr.size() < 60) fr.push_back(8'h00);
    crc = 32'hFFFFFFFF;
    foreach (fr[j]) begin
      for (int b = 0; b < 8; b++) begin
        fb  = crc[0] ^ fr[j][b];
        crc = crc >> 1;
        if (fb) crc = crc ^ 32'hEDB88320;
      end
    end
    crc = ~crc;
    for (int j = 0; j < 7; j++) push_byte(8'h55);
    push_byte(8'hD5);
    foreach (fr[j]) push_byte(fr[j]);
    for (int j = 0; j < 4; j++) push_byte(crc[8*j +: 8]);
  endtask

  // Byte source; optional toggling of txpacket/txdata in the three clocks after each advance.
  task automatic send(input int i, input bytes_t b, input bit toggle, input bit chain,
                      input logic [7:0] nb);
    int n, k, ph, g;
    logic a;
    n = b.size();
    k = 0; ph = 0; g = 0;
    if (n == 0) begin
      tp[i] = 1'b1;
      @(posedge clk); #1;
      tp[i] = 1'b0;
    end else begin
      tp[i] = 1'b1;
      td[i] = b[0];
      while (k < n && g < 4 * n + 300) begin
        @(negedge clk);
        a = adv_w[i];
        @(posedge clk); #1;
        g++;
        if (a) begin
          k++;
          ph = 1;
        end else if (ph != 0) begin
          ph++;
        end
        if (ph == 4) ph = 0;
        if (toggle && ph >= 1 && ph <= 3 && k < n) begin
          tp[i] = 1'($urandom_range(0, 1));
          td[i] = 8'($urandom);
        end else begin
          tp[i] = (k < n);
          if (k < n) td[i] = b[k];
        end
      end
    end
    check_eq("bytes_consumed", k, n);
    if (chain) begin
      repeat (8) @(posedge clk);
      #1;
      tp[i] = 1'b1;
      td[i] = nb;
    end
  endtask

  task automatic wait_idle(input int i);
    int g;
    g = 0;
    @(negedge clk);
    while (busy_w[i] && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check_eq("frame_end_idle", 32'(busy_w[i]), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_frame(input int i, input string tag, input int exp_adv, input int exp_bursts);
    logic [1:0] got[$];
    int bad;
    got = (i == 0) ? cap0 : cap1;
    bad = 0;
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) if (got[k] !== exp_q[k]) bad++;
    check_eq({tag, "_txen_clocks"}, got.size(), exp_q.size());
    check_eq({tag, "_dibit_errs"}, bad, 0);
    check_eq({tag, "_txadvance"}, adv_cnt[i], exp_adv);
    check_eq({tag, "_bursts"}, rises[i], exp_bursts);
    check_eq({tag, "_txd_when_off"}, txd_bad[i], 0);
  endtask

  task automatic rand_frame(input int n, output bytes_t b);
    b.delete();
    for (int j = 0; j < n; j++) b.push_back(8'($urandom));
  endtask

  initial begin
    bytes_t f, g;
    logic [1:0] got[$];
    logic [31:0] fcs;
    tp[0] = 1'b0; tp[1] = 1'b0; td[0] = 8'h00; td[1] = 8'h00;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq("rst_txen", 32'(en_w[i]), 0);
      check_eq("rst_txd", 32'(txd_w[i]), 0);
      check_eq("rst_busy", 32'(busy_w[i]), 0);
      check_eq("rst_adv", 32'(adv_w[i]), 0);
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Standard check vector, no padding.
    f.delete();
    for (int j = 0; j < 9; j++) f.push_back(8'h31 + 8'(j));
    clear_mon(); exp_q.delete(); build_expected(f, 1'b0);
    send(0, f, 1'b0, 1'b0, 8'h00);
    wait_idle(0);
    check_frame(0, "vec9", 9, 1);
    check_eq("vec9_len84", cap0.size(), 84);
    fcs = '0;
    if (cap0.size() >= 16) for (int d = 0; d < 16; d++) fcs[2*d +: 2] = cap0[cap0.size() - 16 + d];
    check_eq("vec9_fcs", int'(fcs), int'(32'hCBF43926));

    // One byte padded to 60.
    f.delete(); f.push_back(8'hAB);
    clear_mon(); exp_q.delete(); build_expected(f, 1'b1);
    send(1, f, 1'b0, 1'b0, 8'h00);
    wait_idle(1);
    check_frame(1, "pad1", 1, 1);
    check_eq("pad1_len288", cap1.size(), 288);

    // Zero-byte frame: a single-clock txpacket pulse.
    f.delete();
    clear_mon(); exp_q.delete(); build_expected(f, 1'b1);
    send(1, f, 1'b0, 1'b0, 8'h00);
    wait_idle(1);
    check_frame(1, "pad0", 0, 1);

    // 70 bytes with mid-byte toggling: no pad, toggles invisible.
    rand_frame(70, f);
    clear_mon(); exp_q.delete(); build_expected(f, 1'b1);
    send(1, f, 1'b1, 1'b0, 8'h00);
    wait_idle(1);
    check_frame(1, "long70", 70, 1);
    check_eq("long70_len", cap1.size(), 32 + 280 + 16);

    // Random frame lengths on both instances, with toggling.
    for (int r = 0; r < 4; r++) begin
      rand_frame($urandom_range(1, 80), f);
      clear_mon(); exp_q.delete(); build_expected(f, r[0]);
      send(r % 2, f, 1'b1, 1'b0, 8'h00);
      wait_idle(r % 2);
      check_frame(r % 2, "rand", f.size(), 1);
    end

    // Back-to-back: next frame requested during FCS/IPG.
    rand_frame($urandom_range(5, 20), f);
    rand_frame($urandom_range(5, 20), g);
    clear_mon(); exp_q.delete(); build_expected(f, 1'b0); build_expected(g, 1'b0);
    send(0, f, 1'b0, 1'b1, g[0]);
    send(0, g, 1'b0, 1'b0, 8'h00);
    wait_idle(0);
    check_frame(0, "b2b", f.size() + g.size(), 2);
    check_eq("b2b_gap", last_gap[0], 48);
    check_eq("b2b_busy_low", last_bgap[0], 1);

    // Reset in the middle of DATA, then a clean frame.
    tp[1] = 1'b1; td[1] = 8'h5A;
    repeat (45) @(posedge clk);
    #1;
    check_eq("pre_rst_busy", 32'(busy_w[1]), 1);
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_txen", 32'(en_w[1]), 0);
    check_eq("midrst_busy", 32'(busy_w[1]), 0);
    check_eq("midrst_txd", 32'(txd_w[1]), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("midrst_adv", 32'(adv_w[1]), 0);
    end
    @(posedge clk); #1;
    tp[1] = 1'b0;
    #3 reset = 1'b0;
    @(posedge clk); #1;
    rand_frame(12, f);
    clear_mon(); exp_q.delete(); build_expected(f, 1'b1);
    send(1, f, 1'b0, 1'b0, 8'h00);
    wait_idle(1);
    check_frame(1, "post_rst", 12, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/eth_rmii_tx.md
ETH_RMII_TX -- requirements
Module: eth_rmii_tx

Interface
REQ-001 SHALL have parameter PAD, default 1, meaning nonzero pads frames to 60 data bytes before FCS.
REQ-002 SHALL have parameter IPG_CYCLES, default 48, meaning the inter-packet gap in clocks (96 bit times at 50 MHz).
REQ-003 SHALL have port clk  input  1  50 MHz RMII reference clock; the block uses one clock and this is it.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port txpacket  input  1  upstream holds high while frame bytes remain; low after last byte consumed.
REQ-006 SHALL have port txdata  input  8  current frame byte, valid while txpacket=1.
REQ-007 SHALL have port txadvance  output  1  one-cycle pulse; txdata is consumed at the clock edge ending that cycle.
REQ-008 SHALL have port txbusy  output  1  high whenever the block is not idle.
REQ-009 SHALL have port rmii_txen  output  1  RMII TX_EN.
REQ-010 SHALL have port rmii_txd  output  2  RMII TXD[1:0], one dibit per clock.

Function
REQ-011 SHALL implement states IDLE, PREAMBLE, DATA, PAD, FCS, IPG; rmii_txen, rmii_txd and txbusy SHALL be registered.
REQ-012 In IDLE, the edge sampling txpacket=1 SHALL enter PREAMBLE and set txbusy=1, rmii_txen=1, rmii_txd=01.
REQ-013 PREAMBLE SHALL drive 32 dibits: 31 of 01, then 11 (0x55 x7, SFD 0xD5, LSB dibit first).
REQ-014 A byte boundary is the cycle driving the last dibit of the SFD, a data byte, or a pad byte.
REQ-015 txadvance SHALL be combinational: high exactly in a PREAMBLE or DATA byte-boundary cycle with txpacket=1; never otherwise.
REQ-016 At the edge ending a txadvance cycle, the block SHALL latch txdata, enter or stay in DATA, and drive txdata[1:0]; then [3:2], [5:4], [7:6] on following clocks.
REQ-017 At a PREAMBLE/DATA byte boundary with txpacket=0: if PAD!=0 and fewer than 60 data bytes were sent, SHALL enter PAD; else SHALL enter FCS.
REQ-018 txpacket changes between byte boundaries SHALL be ignored; upstream gets 3 clocks after txadvance to drop txpacket.
REQ-019 PAD SHALL send 0x00 bytes until 60 total bytes (data+pad) have been sent, then enter FCS; frames of zero data bytes SHALL be padded to 60.
REQ-020 The byte counter SHALL saturate (no wrap) at or above 60; frames longer than 60 SHALL receive no pad.
REQ-021 CRC SHALL be CRC-32 reflected, polynomial 0xEDB88320, init 0xFFFFFFFF, over all data and pad bytes; preamble/SFD excluded.
REQ-022 FCS SHALL send the complemented CRC as 16 dibits, least-significant dibit first, rmii_txen=1.
REQ-023 After the last FCS dibit, the block SHALL drive rmii_txen=0, rmii_txd=00 and hold IPG for IPG_CYCLES clocks with txbusy=1.
REQ-024 At IPG end, the block SHALL enter IDLE and drop txbusy; if txpacket=1 on the first IDLE cycle, the next preamble SHALL start at that edge (back-to-back).
REQ-025 rmii_txen SHALL never deassert between the first preamble dibit and the last FCS dibit.
REQ-026 rmii_txd SHALL be 00 whenever rmii_txen=0.

Reset
REQ-027 reset SHALL immediately (asynchronously) force state IDLE, rmii_txen=0, rmii_txd=00, txbusy=0, CRC=0xFFFFFFFF, byte counter=0, shift register=0.
REQ-028 txadvance SHALL be 0 while reset is high.
REQ-029 Reset mid-frame SHALL truncate the frame with no FCS; after release, the first frame SHALL start with a full preamble.

Verification
REQ-030 Reset: assert reset mid-DATA -> rmii_txen=0, txbusy=0 before next clk edge; no txadvance while reset high.
REQ-031 PAD=0, bytes "123456789" (0x31..0x39) -> 32 preamble dibits, 36 data dibits, FCS bytes 0x26 0x39 0xF4 0xCB; rmii_txen high 84 clocks; exactly 9 txadvance pulses.
REQ-032 PAD=1, one byte 0xAB -> 1 txadvance, 59 zero pad bytes, FCS over 60 bytes matches reference CRC model; rmii_txen high 32+240+16=288 clocks.
REQ-033 PAD=1, txpacket pulses high one clock with no byte consumed -> 60 zero bytes + FCS; zero txadvance pulses.
REQ-034 Back-to-back: txpacket held high through IPG -> exactly 48 clocks rmii_txen=0 between frames; txbusy low for one cycle only at IDLE.
REQ-035 txpacket toggled mid-byte (between boundaries) -> no effect on dibit stream; 70-byte frame with PAD=1 -> no pad inserted.
